horizontal_rocket_mover: RTL and testbench

HORIZONTAL_ROCKET_MOVER -- requirements
Module: horizontal_rocket_mover

---
 rtl/rocket_pkg.sv | 32 +++
 rtl/rise_edge_detector.sv | 31 +++
 rtl/horizontal_rocket_mover.sv | 112 +++++++++++
 tb/tb_horizontal_rocket_mover.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rocket_pkg.sv
// Shared definitions for the horizontal rocket mover.
//   - state_t   : mover FSM states
//   - FRAC_BITS : fraction bits of the X fixed-point position register
//   - POS_W     : width of the X fixed-point register (11 integer + 6 fraction)
//   - PX_W      : width of a pixel coordinate / speed input
//   - SCREEN_W, ROCKET_W, LEFT_LIMIT, RIGHT_LIMIT : screen geometry
//   - fx_to_px  : integer part of a fixed-point X position (truncation)
package rocket_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    EXITED = 2'd2
  } state_t;

  localparam int FRAC_BITS = 6;
  localparam int PX_W      = 11;
  localparam int POS_W     = PX_W + FRAC_BITS;

  localparam int SCREEN_W  = 640;
  localparam int ROCKET_W  = 16;

  localparam logic signed [PX_W-1:0] LEFT_LIMIT  = 11'sd0;
  localparam logic signed [PX_W-1:0] RIGHT_LIMIT = 11'sd624;

  // Drops the fraction bits; arithmetic, no rounding, so negative
  // positions floor toward -infinity.
  function automatic logic signed [PX_W-1:0] fx_to_px(input logic signed [POS_W-1:0] x);
    return x[FRAC_BITS +: PX_W];
  endfunction

endpackage

// File: rtl/rise_edge_detector.sv
// Rising-edge detector for a level input.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   in     : level input
//   pulse  : one-clk high when `in` is high and was low on the previous clk
module rise_edge_detector (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);

  logic r_prev;
  logic r_histValid;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_prev      <= 1'b0;
      r_histValid <= 1'b0;
    end else begin
      r_prev      <= in;
      r_histValid <= 1'b1;
    end
  end

  // Right after reset the previous level is unknown, so no edge is reported
  // until one real sample has been taken. An input already high when reset
  // releases therefore needs a genuine low-to-high transition to fire.
  assign pulse = in & ~r_prev & r_histValid;

endmodule

// File: rtl/horizontal_rocket_mover.sv
// Moves a horizontally flying rocket once per video frame.
//   clk           : system clock (rising edge)
//   resetN        : asynchronous active-low reset
//   startOfFrame  : one-clk pulse per video frame
//   isActive      : rocket-alive level from the rocket controller
//   initialSpeed  : signed speed in pixels/64 per frame (positive = right)
//   initialX/Y    : launch top-left position in pixels
//   topLeftX/Y    : current rocket position in pixels (registered)
//   reachedBorder : level, rocket has left the screen horizontally
//   rocketVisible : high only while flying
module horizontal_rocket_mover
  import rocket_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   isActive,
  input  logic signed [PX_W-1:0] initialSpeed,
  input  logic signed [PX_W-1:0] initialX,
  input  logic signed [PX_W-1:0] initialY,
  output logic signed [PX_W-1:0] topLeftX,
  output logic signed [PX_W-1:0] topLeftY,
  output logic                   reachedBorder,
  output logic                   rocketVisible
);

  state_t                   r_state;
  logic signed [POS_W-1:0]  r_posX;
  logic signed [POS_W-1:0]  r_speed;

  logic                     w_launch;
  logic signed [POS_W-1:0]  w_nextX;
  logic signed [PX_W-1:0]   w_nextPx;
  logic                     w_speedPos;
  logic                     w_speedNeg;
  logic                     w_exit;

  rise_edge_detector u_active_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (isActive),
    .pulse  (w_launch)
  );

  assign w_nextX    = r_posX + r_speed;
  assign w_nextPx   = fx_to_px(w_nextX);
  assign w_speedNeg = r_speed[POS_W-1];
  assign w_speedPos = !r_speed[POS_W-1] && (r_speed != '0);
  // Exit is judged on the post-move pixel position; zero speed never exits.
  assign w_exit     = (w_speedPos && (w_nextPx > RIGHT_LIMIT)) ||
                      (w_speedNeg && (w_nextPx < LEFT_LIMIT));

  // topLeftY doubles as the Y register: Y is constant for the whole flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_posX        <= '0;
      r_speed       <= '0;
      topLeftX      <= '0;
      topLeftY      <= '0;
      reachedBorder <= 1'b0;
      rocketVisible <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          reachedBorder <= 1'b0;
          rocketVisible <= 1'b0;
          // startOfFrame is ignored here, so a launch on a frame pulse
          // shows the launch position for that frame.
          if (w_launch) begin
            r_posX        <= {initialX, {FRAC_BITS{1'b0}}};
            r_speed       <= {{FRAC_BITS{initialSpeed[PX_W-1]}}, initialSpeed};
            topLeftX      <= initialX;
            topLeftY      <= initialY;
            rocketVisible <= 1'b1;
            r_state       <= FLYING;
          end
        end

        FLYING: begin
          if (!isActive) begin
            rocketVisible <= 1'b0;
            r_state       <= IDLE;
          end else if (startOfFrame) begin
            r_posX   <= w_nextX;
            topLeftX <= w_nextPx;
            if (w_exit) begin
              reachedBorder <= 1'b1;
              rocketVisible <= 1'b0;
              r_state       <= EXITED;
            end
          end
        end

        EXITED: begin
          // Position frozen; border flag held until the controller drops isActive.
          if (!isActive) begin
            reachedBorder <= 1'b0;
            r_state       <= IDLE;
          end
        end

        default: begin
          reachedBorder <= 1'b0;
          rocketVisible <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_horizontal_rocket_mover.sv
module tb_horizontal_rocket_mover;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               isActive;
  logic signed [10:0] initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               reachedBorder;
  logic               rocketVisible;

  int n_checks = 0;
  int n_fail   = 0;

  horizontal_rocket_mover dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .isActive      (isActive),
    .initialSpeed  (initialSpeed),
    .initialX      (initialX),
    .initialY      (initialY),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .reachedBorder (reachedBorder),
    .rocketVisible (rocketVisible)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic launch(input int x, input int y, input int spd);
    initialX     = 11'(x);
    initialY     = 11'(y);
    initialSpeed = 11'(spd);
    isActive     = 1'b1;
    tick();
  endtask

  task automatic drop();
    isActive = 1'b0;
    tick();
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    isActive     = 1'b0;
    initialSpeed = '0;
    initialX     = '0;
    initialY     = '0;
    tick();
    tick();
    check_eq("rst_x",   topLeftX,      0);
    check_eq("rst_y",   topLeftY,      0);
    check_eq("rst_rb",  reachedBorder, 0);
    check_eq("rst_vis", rocketVisible, 0);
    resetN = 1'b1;
    tick();
    tick();

    // Launch right at +2 px/frame.
    launch(0, 450, 128);
    check_eq("launch_x",   topLeftX,      0);
    check_eq("launch_vis", rocketVisible, 1);
    frames(3);
    check_eq("right3_x",   topLeftX,      6);
    check_eq("right3_y",   topLeftY,      450);
    check_eq("right3_vis", rocketVisible, 1);

    // Continue to frame 312 (x=624, still inside), then 313 exits.
    frames(309);
    check_eq("right312_x",  topLeftX,      624);
    check_eq("right312_rb", reachedBorder, 0);
    frames(1);
    check_eq("right313_x",   topLeftX,      626);
    check_eq("right313_rb",  reachedBorder, 1);
    check_eq("right313_vis", rocketVisible, 0);
    frames(2);
    check_eq("exited_hold_rb", reachedBorder, 1);
    check_eq("exited_hold_x",  topLeftX,      626);
    drop();
    check_eq("exited_drop_rb", reachedBorder, 0);
    tick();
    check_eq("idle_keep_x", topLeftX, 626);
    check_eq("idle_vis",    rocketVisible, 0);

    // Exit left at -2 px/frame.
    launch(624, 100, -128);
    frames(312);
    check_eq("left312_x",  topLeftX,      0);
    check_eq("left312_rb", reachedBorder, 0);
    frames(1);
    check_eq("left313_x",  topLeftX,      -2);
    check_eq("left313_rb", reachedBorder, 1);
    drop();
    check_eq("left_drop_rb", reachedBorder, 0);

    // Collision: isActive dropped mid-flight.
    launch(0, 200, 128);
    frames(10);
    check_eq("coll10_x", topLeftX, 20);
    drop();
    check_eq("coll_vis", rocketVisible, 0);
    check_eq("coll_rb",  reachedBorder, 0);
    check_eq("coll_x",   topLeftX,      20);
    frames(2);
    check_eq("coll_idle_rb", reachedBorder, 0);
    check_eq("coll_idle_x",  topLeftX,      20);

    // Launch coincident with startOfFrame: load wins, no move that frame.
    initialX     = 11'sd100;
    initialY     = 11'sd50;
    initialSpeed = 11'sd128;
    isActive     = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check_eq("coinc_x",   topLeftX,      100);
    check_eq("coinc_vis", rocketVisible, 1);
    tick();
    check_eq("coinc_x2",  topLeftX,      100);
    frames(1);
    check_eq("coinc_move_x", topLeftX, 102);
    drop();

    // Fractional carry at +65/64 px/frame: 63*65=4095 -> 63, 64*65=4160 -> 65.
    launch(0, 10, 65);
    frames(63);
    check_eq("frac63_x", topLeftX, 63);
    frames(1);
    check_eq("frac64_x", topLeftX, 65);
    drop();

    // Zero speed never exits.
    launch(5, 0, 0);
    frames(5);
    check_eq("zero_x",   topLeftX,      5);
    check_eq("zero_rb",  reachedBorder, 0);
    check_eq("zero_vis", rocketVisible, 1);
    drop();

    // Reset mid-flight, isActive held high through and after release.
    launch(0, 300, 128);
    frames(50);
    check_eq("pre_rst_x", topLeftX, 100);
    resetN = 1'b0;
    #1;
    check_eq("midrst_x",   topLeftX,      0);
    check_eq("midrst_y",   topLeftY,      0);
    check_eq("midrst_rb",  reachedBorder, 0);
    check_eq("midrst_vis", rocketVisible, 0);
    tick();
    resetN = 1'b1;
    initialX = 11'sd40;
    frames(3);
    check_eq("norelaunch_vis", rocketVisible, 0);
    check_eq("norelaunch_x",   topLeftX,      0);
    drop();
    launch(40, 300, 128);
    check_eq("relaunch_vis", rocketVisible, 1);
    check_eq("relaunch_x",   topLeftX,      40);
    check_eq("relaunch_y",   topLeftY,      300);
    drop();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
